// File: rtl/pipe_fire_ctrl.sv
// pipe_fire_ctrl: valid/fire sequencer for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Latency: fire strobes and o_launch are combinational from stage valids and handshakes; valids update next edge.
// Backpressure: a held or unacknowledged stage stalls every older stage behind it through the ready chain.
// Optional feature macro PIPE_STALL_CNT_EN adds o_stall_cnt, a saturating count of RUN cycles where ID is stuck.
module pipe_fire_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic             i_halt,
  input  logic             i_if_valid,
  input  logic             i_hazard,
  input  logic             i_mem_wait,
  input  logic             i_flush,
  input  logic             i_wb_ack,
  output logic             o_fire_IF,
  output logic             o_fire_ID,
  output logic             o_fire_EX,
  output logic             o_fire_MEM,
  output logic             o_fire_WB,
  output logic             o_launch,
  output logic [4:0]       o_valid,
  output logic [1:0]       o_state,
  output logic             o_busy,
`ifdef PIPE_STALL_CNT_EN
  output logic [CNT_W-1:0] o_stall_cnt,
`endif
  output logic [CNT_W-1:0] o_retire_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       valid_q, valid_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic rdy_if, rdy_id, rdy_ex, rdy_mem, rdy_wb;
  logic fire_if, fire_id, fire_ex, fire_mem, fire_wb;
  logic launch;
  logic any_fire;

  // Ready chain evaluated from WB backward so a hold anywhere ripples to every older stage.
  always_comb begin
    rdy_wb   = i_wb_ack;
    fire_wb  = valid_q[4] & rdy_wb;
    rdy_mem  = ~valid_q[4] | fire_wb;
    fire_mem = valid_q[3] & rdy_mem & ~i_mem_wait;
    rdy_ex   = ~valid_q[3] | fire_mem;
    fire_ex  = valid_q[2] & rdy_ex;
    rdy_id   = ~valid_q[2] | fire_ex;
    // A flush kills IF and ID outright, so it dominates a simultaneous load-use hold.
    fire_id  = valid_q[1] & rdy_id & ~i_hazard & ~i_flush;
    rdy_if   = ~valid_q[1] | fire_id;
    fire_if  = valid_q[0] & rdy_if & ~i_flush;
    launch   = (state_q == ST_RUN) & i_if_valid & ~i_flush & (~valid_q[0] | fire_if);
    any_fire = fire_if | fire_id | fire_ex | fire_mem | fire_wb;
  end

  // Next valid bits: a stage is occupied if something arrives, or its occupant stays and is not killed.
  always_comb begin
    valid_d    = '0;
    valid_d[0] = launch  | (valid_q[0] & ~fire_if  & ~i_flush);
    valid_d[1] = fire_if | (valid_q[1] & ~fire_id  & ~i_flush);
    valid_d[2] = fire_id | (valid_q[2] & ~fire_ex);
    valid_d[3] = fire_ex | (valid_q[3] & ~fire_mem);
    valid_d[4] = fire_mem | (valid_q[4] & ~fire_wb);
    retire_cnt_d = retire_cnt_q + CNT_W'(fire_wb);
  end

  // Run-control FSM; halt beats a simultaneous start while running, drain ends once the pipe is empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_start) state_d = ST_RUN;
      ST_RUN:    if (i_halt)  state_d = ST_DRAIN;
      ST_DRAIN:  if ((valid_q == 5'b0) && !any_fire) state_d = ST_HALTED;
      ST_HALTED: if (i_start) state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Pipeline state registers; reset drops every in-flight instruction at once.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      valid_q      <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_inc;

  // Count RUN cycles where ID holds an instruction it cannot pass on; saturate instead of wrapping.
  always_comb begin
    stall_inc   = (state_q == ST_RUN) & valid_q[1] & ~fire_id & ~i_flush;
    stall_cnt_d = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

  assign o_fire_IF    = fire_if;
  assign o_fire_ID    = fire_id;
  assign o_fire_EX    = fire_ex;
  assign o_fire_MEM   = fire_mem;
  assign o_fire_WB    = fire_wb;
  assign o_launch     = launch;
  assign o_valid      = valid_q;
  assign o_state      = state_q;
  assign o_busy       = |valid_q;
  assign o_retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_pipe_fire_ctrl.sv
// Bench for pipe_fire_ctrl: directed scenarios plus randomized traffic against a slot-occupancy model.
module tb_pipe_fire_ctrl;

`ifdef PIPE_STALL_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif
  localparam int CMOD = 1 << CNT_W;

  logic i_clk, i_rstn;
  logic i_start, i_halt, i_if_valid, i_hazard, i_mem_wait, i_flush, i_wb_ack;
  logic o_fire_IF, o_fire_ID, o_fire_EX, o_fire_MEM, o_fire_WB, o_launch, o_busy;
  logic [4:0] o_valid;
  logic [1:0] o_state;
  logic [CNT_W-1:0] o_retire_cnt;
`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] o_stall_cnt;
`endif

  pipe_fire_ctrl #(.CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_halt(i_halt),
    .i_if_valid(i_if_valid), .i_hazard(i_hazard), .i_mem_wait(i_mem_wait),
    .i_flush(i_flush), .i_wb_ack(i_wb_ack),
    .o_fire_IF(o_fire_IF), .o_fire_ID(o_fire_ID), .o_fire_EX(o_fire_EX),
    .o_fire_MEM(o_fire_MEM), .o_fire_WB(o_fire_WB), .o_launch(o_launch),
    .o_valid(o_valid), .o_state(o_state), .o_busy(o_busy),
`ifdef PIPE_STALL_CNT_EN
    .o_stall_cnt(o_stall_cnt),
`endif
    .o_retire_cnt(o_retire_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: five slots, each either empty or holding an instruction
  bit [4:0] m_occ    = '0;
  int       m_state  = 0;   // 0 IDLE, 1 RUN, 2 DRAIN, 3 HALTED
  int       m_retire = 0;
  int       m_stall  = 0;

  // Walk from the oldest slot: an instruction moves if the slot ahead will be free and nothing pins it.
  function automatic void model_comb(output bit [4:0] mv, output bit ln);
    bit ahead_free;
    bit pinned;
    mv = '0;
    ahead_free = i_wb_ack;
    for (int k = 4; k >= 0; k--) begin
      pinned = (k == 1 && i_hazard) || (k == 3 && i_mem_wait) || (k < 2 && i_flush);
      mv[k] = m_occ[k] && ahead_free && !pinned;
      ahead_free = !m_occ[k] || mv[k];
    end
    ln = (m_state == 1) && i_if_valid && !i_flush && ahead_free;
  endfunction

  bit [4:0] u_mv, u_nocc;
  bit       u_ln;
  always @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      m_occ    <= '0;
      m_state  <= 0;
      m_retire <= 0;
      m_stall  <= 0;
    end else begin
      model_comb(u_mv, u_ln);
      u_nocc[0] = u_ln;
      for (int k = 0; k < 5; k++) begin
        if (k > 0) u_nocc[k] = u_mv[k-1];
        if (m_occ[k] && !u_mv[k] && !(i_flush && k < 2)) u_nocc[k] = 1'b1;
      end
      m_occ    <= u_nocc;
      m_retire <= m_retire + int'(u_mv[4]);
      if (m_state == 1 && m_occ[1] && !u_mv[1] && !i_flush && m_stall < CMOD - 1)
        m_stall <= m_stall + 1;
      case (m_state)
        0, 3: if (i_start) m_state <= 1;
        1:    if (i_halt) m_state <= 2;
        2:    if (m_occ == 5'b0) m_state <= 3;
        default: m_state <= 0;
      endcase
    end
  end

  // Compare every cycle, half a period away from the active edge.
  bit       cmp_en = 1'b1;
  bit [4:0] c_mv;
  bit       c_ln;
  always @(negedge i_clk) begin
    if (cmp_en) begin
      model_comb(c_mv, c_ln);
      chk("fire_IF",  32'(o_fire_IF),  32'(c_mv[0]));
      chk("fire_ID",  32'(o_fire_ID),  32'(c_mv[1]));
      chk("fire_EX",  32'(o_fire_EX),  32'(c_mv[2]));
      chk("fire_MEM", 32'(o_fire_MEM), 32'(c_mv[3]));
      chk("fire_WB",  32'(o_fire_WB),  32'(c_mv[4]));
      chk("launch",   32'(o_launch),   32'(c_ln));
      chk("valid",    32'(o_valid),    32'(m_occ));
      chk("state",    32'(o_state),    32'(m_state));
      chk("busy",     32'(o_busy),     32'(|m_occ));
      chk("retire",   32'(o_retire_cnt), 32'(m_retire % CMOD));
`ifdef PIPE_STALL_CNT_EN
      chk("stall",    32'(o_stall_cnt), 32'(m_stall));
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  int n, rets, lnch, r0;

  initial begin
    i_rstn = 1'b0; i_start = 0; i_halt = 0; i_if_valid = 0; i_hazard = 0;
    i_mem_wait = 0; i_flush = 0; i_wb_ack = 0;
    cyc(); cyc();
    @(negedge i_clk);
    chk("rst_state",  32'(o_state), 32'd0);
    chk("rst_valid",  32'(o_valid), 32'd0);
    chk("rst_retire", 32'(o_retire_cnt), 32'd0);
    cyc();
    i_rstn = 1'b1;
    cyc();

    // Streaming: first retire five cycles after first launch, then one per cycle.
    i_start = 1; i_if_valid = 1; i_wb_ack = 1;
    cyc();
    i_start = 0;
    @(negedge i_clk);
    chk("first_launch", 32'(o_launch), 32'd1);
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      @(negedge i_clk);
      if (o_fire_WB) begin n = i; break; end
    end
    chk("first_wb_latency", 32'(n), 32'd5);
    repeat (16) cyc();
    @(negedge i_clk);
    chk("stream_retire", 32'(o_retire_cnt), 32'(16 % CMOD));
    chk("stream_full",   32'(o_valid), 32'h1f);

    // Load-use hold for two cycles.
    cyc();
    i_hazard = 1;
    @(negedge i_clk);
    chk("haz1_fire", 32'({o_fire_IF, o_fire_ID, o_launch}), 32'd0);
    cyc();
    @(negedge i_clk);
    chk("haz2_fire", 32'({o_fire_IF, o_fire_ID, o_launch}), 32'd0);
    chk("haz2_ex_bubble", 32'(o_valid[2]), 32'd0);
    cyc();
    i_hazard = 0;
`ifdef PIPE_STALL_CNT_EN
    @(negedge i_clk);
    chk("haz_stall_cnt", 32'(o_stall_cnt), 32'd2);
`endif
    repeat (6) cyc();

    // Backpressure: WB not acknowledged for six cycles with a full pipe.
    i_wb_ack = 0;
    @(negedge i_clk);
    r0 = int'(o_retire_cnt);
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      chk("bp_fires", 32'({o_fire_IF, o_fire_ID, o_fire_EX, o_fire_MEM, o_fire_WB, o_launch}), 32'd0);
      chk("bp_valid", 32'(o_valid), 32'h1f);
      cyc();
    end
    @(negedge i_clk);
    chk("bp_no_retire", 32'(o_retire_cnt), 32'(r0));
    i_wb_ack = 1;
    cyc();
    @(negedge i_clk);
    chk("bp_release_retire", 32'(o_retire_cnt), 32'((r0 + 1) % CMOD));

    // Flush with IF, ID and EX all valid.
    cyc();
    i_flush = 1;
    @(negedge i_clk);
    chk("flush_fires", 32'({o_fire_IF, o_fire_ID, o_launch}), 32'd0);
    cyc();
    i_flush = 0;
    @(negedge i_clk);
    chk("flush_valid_low", 32'(o_valid[3:0]), 32'b1000);

    // Drain and halt with a full pipe.
    repeat (8) cyc();
    @(negedge i_clk);
    chk("pre_halt_full", 32'(o_valid), 32'h1f);
    cyc();
    i_halt = 1;
    cyc();
    i_halt = 0;
    rets = 0; lnch = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (o_state == 2'b11) break;
      rets += int'(o_fire_WB);
      lnch += int'(o_launch);
      cyc();
    end
    chk("drain_retires",  32'(rets), 32'd5);
    chk("drain_launches", 32'(lnch), 32'd0);
    chk("halted_state",   32'(o_state), 32'd3);
    chk("halted_busy",    32'(o_busy), 32'd0);
    cyc();
    i_start = 1;
    cyc();
    i_start = 0;
    @(negedge i_clk);
    chk("restart_state", 32'(o_state), 32'd1);

    // Asynchronous reset mid-stream with memory held busy.
    i_mem_wait = 1;
    repeat (6) cyc();
    @(posedge i_clk);
    #3;
    i_rstn = 0;
    #1;
    chk("arst_valid",  32'(o_valid), 32'd0);
    chk("arst_state",  32'(o_state), 32'd0);
    chk("arst_retire", 32'(o_retire_cnt), 32'd0);
    chk("arst_fires",  32'({o_fire_IF, o_fire_ID, o_fire_EX, o_fire_MEM, o_fire_WB, o_launch}), 32'd0);
    cyc();
    i_rstn = 1;
    cyc();

`ifdef PIPE_STALL_CNT_EN
    // Long memory stall: stall counter must stop at all-ones.
    i_start = 1;
    cyc();
    i_start = 0;
    repeat (30) cyc();
    @(negedge i_clk);
    chk("stall_saturate", 32'(o_stall_cnt), 32'd15);
`endif
    i_mem_wait = 0;
    cyc();

    // Randomized traffic, including occasional mid-stream resets.
    for (int i = 0; i < 3000; i++) begin
      i_start    = ($urandom_range(0, 99) < 8);
      i_halt     = ($urandom_range(0, 99) < 3);
      i_if_valid = ($urandom_range(0, 99) < 70);
      i_hazard   = ($urandom_range(0, 99) < 15);
      i_mem_wait = ($urandom_range(0, 99) < 20);
      i_flush    = ($urandom_range(0, 99) < 10);
      i_wb_ack   = ($urandom_range(0, 99) < 75);
      i_rstn     = ($urandom_range(0, 999) >= 3);
      cyc();
    end
    i_rstn = 1;
    cyc();

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
